mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath. It accepts one instruction at a time from the fetch unit using a valid/ready handshake, decodes the opcode and funct fields, and steps the datapath through DECODE, EXEC, MEM and WB. In each state it drives the datapath control signals (RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump) and a PC-advance strobe. It also waits on data-memory ready with a timeout and counts retired instructions.

Parameters:
MEM_TIMEOUT, 15, maximum MEM-state cycles to wait for mem_ready before aborting (must be at least 1).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; synchronous, active-high.
instr_valid  in  1  fetch unit presents an instruction.
instr_ready  out  1  controller can accept an instruction (IDLE only).
opcode  in  6  Instructions[31:26]; sampled on the handshake.
funct  in  6  Instructions[5:0]; sampled on the handshake.
Zero  in  1  ALU zero flag from the datapath.
mem_ready  in  1  data memory has completed the access.
RegDst  out  1  selects rd (1) or rt (0) as the write register.
RegWr  out  1  register-file write enable.
ALUsrc  out  1  selects the immediate (1) or Db (0) as ALU operand B.
ALUcntrl  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
MemWr  out  1  data-memory write enable.
MemToReg  out  1  selects memory (1) or ALU (0) as write-back data.
Branch  out  1  beq evaluation strobe.
Jump  out  1  jump strobe.
pc_en  out  1  one-cycle PC update; marks retirement.
illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
mem_err  out  1  one-cycle pulse on a memory timeout.
retire_count  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, DECODE, EXEC, MEM, WB. opcode and funct are latched into internal registers on the handshake (instr_valid && instr_ready). No other inputs are latched.
- Reset takes effect on the clock edge. After reset the state is IDLE, retire_count is 0, the timeout counter is 0, and every output is 0. instr_ready is 0 while rst is high. Reset asserted mid-instruction aborts it with no RegWr, MemWr or pc_en.
- IDLE: instr_ready=1. On the handshake, go to DECODE. If instr_valid is low, stay in IDLE.
- Supported instructions:
  - R-type (opcode 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- DECODE:
  - Unsupported opcode or funct: illegal=1, go to IDLE. No pc_en and no retire.
  - j: Jump=1, pc_en=1, go to IDLE.
  - Everything else: go to EXEC.
- EXEC:
  - R-type: RegDst=1, ALUsrc=0, ALUcntrl taken from funct, go to WB.
  - addi/lw/sw: ALUsrc=1, ALUcntrl=00. addi goes to WB; lw and sw go to MEM.
  - beq: ALUsrc=0, ALUcntrl=01, Branch=1, pc_en=1, go to IDLE. The datapath and fetch unit use Zero; the controller ignores it.
- MEM:
  - sw: MemWr=1 every cycle in MEM.
  - lw: MemToReg=1.
  - If mem_ready=1: sw asserts pc_en and goes to IDLE; lw goes to WB.
  - The timeout counter increments each MEM cycle without mem_ready. When it reaches MEM_TIMEOUT: mem_err=1, go to IDLE, no pc_en.
  - If mem_ready arrives on the timeout cycle, mem_ready wins and no mem_err is raised.
  - The counter clears on MEM entry.
- WB: RegWr=1 for exactly one cycle, pc_en=1, go to IDLE. R-type: RegDst=1. addi/lw: RegDst=0. lw: MemToReg=1.
- Operand-select stability: RegDst, ALUsrc, ALUcntrl and MemToReg hold their EXEC values through MEM and WB of the same instruction.
- Default values: any control not asserted by the current state is 0. Outputs are combinational from the state and latched fields.
- Retirement: retire_count increments on the cycle after each pc_en and wraps from all-ones to 0.
- Latency from the handshake cycle to the pc_en cycle inclusive:
  - j: 2.
  - beq: 3.
  - R-type and addi: 4.
  - sw: 4 + memory wait cycles.
  - lw: 5 + memory wait cycles.
  - The next handshake can occur in the cycle after pc_en.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR);
  - ALUcntrl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR).
- Sub-module mips_alu_decode: combinational {opcode, funct} -> {ALUcntrl, is_legal, instruction class}. It is shared with the FSM and testable standalone.

Test Plan:
1. Reset, then addi (0x08), instr_valid held high -> DECODE, EXEC (ALUsrc=1, ALUcntrl=00), WB (RegWr=1, RegDst=0, pc_en=1). instr_ready returns 1 on the next cycle; retire_count=1.
2. R-type sub (0x00/0x22) followed by or (0x25) -> EXEC shows ALUcntrl=01 then 11, RegDst=1 in both EXEC and WB, exactly one RegWr cycle per instruction.
3. sw with mem_ready low for 3 cycles -> MemWr=1 for 4 cycles, pc_en on the mem_ready cycle. lw with mem_ready high immediately -> MemToReg=1 in MEM and WB, RegWr in WB, 5-cycle latency.
4. lw with mem_ready stuck low, MEM_TIMEOUT=15 -> mem_err pulses after 15 MEM cycles, no RegWr, no pc_en, retire_count unchanged. Repeat with mem_ready rising on cycle 15 -> no mem_err and normal completion.
5. Opcode 0x3F, then R-type with funct 0x00 -> illegal pulses once each, back to IDLE, no pc_en. Then j -> Jump=1 and pc_en=1 in DECODE. Then beq -> Branch=1, ALUcntrl=01 in EXEC.
6. rst asserted during MEM of an sw -> next cycle IDLE, MemWr=0, retire_count=0, instr_ready=0 while rst is high. Force retire_count to all-ones and retire one instruction -> wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct, ALU and instruction-class encodings for the MIPS multi-cycle controller
package mips_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_ILL, C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J} iclass_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_OR   = 2'b11;
endpackage

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: combinational {opcode, funct} -> {alu_op, legal, cls}
// ports: opcode/funct in; alu_op ALU operation, legal supported-instruction flag, cls instruction class (C_ILL when unsupported)
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] alu_op,
  output logic       legal,
  output iclass_t    cls
);
  always_comb begin
    alu_op = ALU_ADD;
    cls = C_ILL;
    case (opcode)
      OP_RTYPE: begin
        alu_op = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR : ALU_ADD;
        cls = (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR}) ? C_R : C_ILL;
      end
      OP_ADDI: cls = C_ADDI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ: begin
        alu_op = ALU_SUB;
        cls = C_BEQ;
      end
      OP_J:    cls = C_J;
      default: cls = C_ILL;
    endcase
    legal = cls != C_ILL;
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control sequencer (IDLE/DECODE/EXEC/MEM/WB) with memory timeout and retire counter
// ports: clk, rst (sync, active-high); instr_valid/instr_ready handshake with opcode/funct; Zero, mem_ready from datapath;
// datapath controls RegDst..Jump, pc_en retirement strobe, illegal and mem_err pulses, retire_count
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             RegWr,
  output logic             ALUsrc,
  output logic [1:0]       ALUcntrl,
  output logic             MemWr,
  output logic             MemToReg,
  output logic             Branch,
  output logic             Jump,
  output logic             pc_en,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] retire_count
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  state_t state;
  logic [5:0] op_q, fn_q;
  logic [TW-1:0] tmo;
  logic [1:0] alu_op;
  logic legal;
  iclass_t cls;
  logic in_dec, in_exe, in_mem, in_wb, in_ops, zero_unused;
  assign zero_unused = Zero;
  mips_alu_decode u_dec (.opcode(op_q), .funct(fn_q), .alu_op(alu_op), .legal(legal), .cls(cls));
  // rst gates every state strobe so an aborted instruction never writes or retires
  assign in_dec = !rst && state == S_DECODE;
  assign in_exe = !rst && state == S_EXEC;
  assign in_mem = !rst && state == S_MEM;
  assign in_wb  = !rst && state == S_WB;
  assign in_ops = in_exe || in_mem || in_wb;
  always_comb begin
    instr_ready = !rst && state == S_IDLE;
    RegDst = in_ops && cls == C_R;
    ALUsrc = in_ops && (cls == C_ADDI || cls == C_LW || cls == C_SW);
    ALUcntrl = in_ops ? alu_op : ALU_ADD;
    MemToReg = (in_mem || in_wb) && cls == C_LW;
    MemWr = in_mem && cls == C_SW;
    RegWr = in_wb;
    Branch = in_exe && cls == C_BEQ;
    Jump = in_dec && cls == C_J;
    illegal = in_dec && !legal;
    mem_err = in_mem && !mem_ready && tmo == TW'(MEM_TIMEOUT - 1);
    pc_en = Jump || Branch || (MemWr && mem_ready) || in_wb;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmo <= '0;
      retire_count <= '0;
      op_q <= '0;
      fn_q <= '0;
    end else begin
      retire_count <= retire_count + CNT_W'(pc_en);
      case (state)
        S_IDLE: if (instr_valid) begin
          op_q <= opcode;
          fn_q <= funct;
          state <= S_DECODE;
        end
        S_DECODE: state <= (!legal || cls == C_J) ? S_IDLE : S_EXEC;
        S_EXEC: begin
          tmo <= '0;
          state <= cls == C_BEQ ? S_IDLE : (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
        end
        S_MEM: begin
          tmo <= tmo + TW'(!mem_ready);
          state <= mem_ready ? (cls == C_LW ? S_WB : S_IDLE) : mem_err ? S_IDLE : S_MEM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scoreboard bench; per-cycle expected control vectors are queued per instruction and checked each cycle
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic rdy, rd, rw, as;
    logic [1:0] alu;
    logic mw, mr, br, jp, pc, il, me;
    logic [2:0] rc;
  } ov_t;
  logic clk = 0, rst = 1, instr_valid = 0, Zero = 0, mem_ready = 0;
  logic [5:0] opcode = '0, funct = '0;
  logic instr_ready, RegDst, RegWr, ALUsrc, MemWr, MemToReg, Branch, Jump, pc_en, illegal, mem_err;
  logic [1:0] ALUcntrl;
  logic [2:0] retire_count;
  ov_t q[$];
  int total = 0, bad = 0;
  logic [2:0] rc_m = '0;
  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .RegDst(RegDst), .RegWr(RegWr), .ALUsrc(ALUsrc), .ALUcntrl(ALUcntrl),
    .MemWr(MemWr), .MemToReg(MemToReg), .Branch(Branch), .Jump(Jump),
    .pc_en(pc_en), .illegal(illegal), .mem_err(mem_err), .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic put(input ov_t v);
    v.rc = rc_m;
    q.push_back(v);
    if (v.pc) rc_m++;
  endtask
  task automatic cyc(input string tag, input logic v_, input logic [5:0] op, input logic [5:0] fn, input logic mr);
    ov_t e, o;
    instr_valid = v_;
    opcode = op;
    funct = fn;
    mem_ready = mr;
    Zero = 1'($urandom);
    @(negedge clk);
    o = {instr_ready, RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg, Branch, Jump, pc_en, illegal, mem_err, retire_count};
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %b, expected vector queue empty", tag, o);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        bad++;
        $error("FAIL %s: got %b expected %b (rdy rd rw as alu mw mr br jp pc il me rc)", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn, input int nw);
    ov_t v;
    logic isr, legal, mem;
    logic [1:0] a;
    int i;
    isr = op == 6'h00;
    mem = op == 6'h23 || op == 6'h2B;
    a = !isr ? (op == 6'h04 ? 2'b01 : 2'b00) : fn == 6'h22 ? 2'b01 : fn == 6'h24 ? 2'b10 : fn == 6'h25 ? 2'b11 : 2'b00;
    legal = isr ? (fn inside {6'h20, 6'h22, 6'h24, 6'h25}) : (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
    v = '0; v.rdy = 1; put(v);
    v = '0; v.il = !legal; v.jp = legal && op == 6'h02; v.pc = v.jp; put(v);
    if (legal && op != 6'h02) begin
      v = '0; v.alu = a; v.rd = isr; v.as = op inside {6'h08, 6'h23, 6'h2B}; v.br = op == 6'h04; v.pc = v.br; put(v);
      if (mem) for (int k = 1; k <= 15; k++) begin
        v.mw = op == 6'h2B; v.mr = op == 6'h23; v.pc = (k == nw + 1) && op == 6'h2B; v.me = k == 15 && nw >= 15;
        put(v);
        if (k == nw + 1 || v.me) break;
      end
      if (op != 6'h04 && op != 6'h2B && !(op == 6'h23 && nw >= 15)) begin
        v.mw = 0; v.me = 0; v.br = 0; v.pc = 1; v.rw = 1; v.mr = op == 6'h23; put(v);
      end
    end
    i = 0;
    while (q.size() > 0) begin
      cyc(tag, i == 0, i == 0 ? op : 6'($urandom), i == 0 ? fn : 6'($urandom), mem && i == 3 + nw);
      i++;
    end
  endtask
  task automatic idle(input string tag);
    ov_t v;
    v = '0; v.rdy = 1; put(v);
    cyc(tag, 1'b0, 6'h08, 6'h20, 1'b0);
  endtask
  initial begin
    ov_t v;
    @(posedge clk);
    #1;
    v = '0; put(v);
    cyc("reset", 1'b0, 6'h00, 6'h00, 1'b0);
    rst = 0;
    rc_m = '0;
    idle("idle");
    run_instr("addi", 6'h08, 6'h11, 0);
    run_instr("r_sub", 6'h00, 6'h22, 0);
    run_instr("r_or", 6'h00, 6'h25, 0);
    run_instr("r_add", 6'h00, 6'h20, 0);
    run_instr("r_and", 6'h00, 6'h24, 0);
    idle("idle2");
    run_instr("sw_wait3", 6'h2B, 6'h00, 3);
    run_instr("lw_fast", 6'h23, 6'h00, 0);
    run_instr("lw_timeout", 6'h23, 6'h00, 15);
    run_instr("lw_ready15", 6'h23, 6'h00, 14);
    run_instr("ill_op", 6'h3F, 6'h20, 0);
    run_instr("ill_fn", 6'h00, 6'h00, 0);
    run_instr("jump", 6'h02, 6'h00, 0);
    run_instr("beq", 6'h04, 6'h00, 0);
    run_instr("sw_fast", 6'h2B, 6'h00, 0);
    v = '0; v.rdy = 1; put(v);
    cyc("rst_sw_hs", 1'b1, 6'h2B, 6'h00, 1'b0);
    v = '0; put(v);
    cyc("rst_sw_dec", 1'b0, 6'h00, 6'h00, 1'b0);
    v = '0; v.as = 1; put(v);
    cyc("rst_sw_exe", 1'b0, 6'h00, 6'h00, 1'b0);
    v.mw = 1; put(v);
    cyc("rst_sw_mem", 1'b0, 6'h00, 6'h00, 1'b0);
    rst = 1;
    v = '0; put(v);
    cyc("rst_abort", 1'b0, 6'h00, 6'h00, 1'b1);
    rc_m = '0;
    v = '0; put(v);
    cyc("rst_held", 1'b1, 6'h08, 6'h00, 1'b1);
    rst = 0;
    run_instr("addi_post_rst", 6'h08, 6'h00, 0);
    idle("idle_end");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
